// File: rtl/score_bcd_counter.sv
// Piano-game score keeper: 4-digit saturating BCD score, miss counter,
// IDLE/PLAY/OVER control and the digit-scan select for the display stage.
module score_bcd_counter #(
  parameter int unsigned SCAN_DIV_BITS = 17,
  parameter int unsigned MAX_MISS      = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       hit,
  input  logic       miss,
  output logic [3:0] four_bcd,
  output logic [3:0] three_bcd,
  output logic [3:0] two_bcd,
  output logic [3:0] one_bcd,
  output logic [1:0] clk_scan,
  output logic [3:0] miss_cnt,
  output logic       playing,
  output logic       game_over
);

  localparam int unsigned DIGIT_W = 4;
  localparam int unsigned SCORE_W = 4 * DIGIT_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    OVER = 2'd2
  } state_t;

  state_t                   state, state_n;
  logic [SCORE_W-1:0]       score, score_n;
  logic [DIGIT_W-1:0]       miss_n;
  logic [SCAN_DIV_BITS-1:0] div;
  logic                     start_q, hit_q, miss_q;
  logic                     armed;
  logic                     start_rise, hit_rise, miss_rise;

  // Saturating 4-digit BCD increment; 9999 holds.
  function automatic logic [SCORE_W-1:0] bcd_inc(input logic [SCORE_W-1:0] s);
    logic [SCORE_W-1:0] r;
    logic               carry;
    r     = s;
    carry = 1'b1;
    if (s != 16'h9999) begin
      for (int i = 0; i < 4; i++) begin
        if (carry) begin
          if (r[DIGIT_W*i +: DIGIT_W] == 4'd9) begin
            r[DIGIT_W*i +: DIGIT_W] = 4'd0;
          end else begin
            r[DIGIT_W*i +: DIGIT_W] = r[DIGIT_W*i +: DIGIT_W] + 4'd1;
            carry = 1'b0;
          end
        end
      end
    end
    return r;
  endfunction

  // The first clock after reset only loads the edge registers, so a level
  // already high when reset is released never counts as an event.
  assign start_rise = start & ~start_q & armed;
  assign hit_rise   = hit   & ~hit_q   & armed;
  assign miss_rise  = miss  & ~miss_q  & armed;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      start_q <= 1'b0;
      hit_q   <= 1'b0;
      miss_q  <= 1'b0;
      armed   <= 1'b0;
      div     <= '0;
    end else begin
      start_q <= start;
      hit_q   <= hit;
      miss_q  <= miss;
      armed   <= 1'b1;
      div     <= div + SCAN_DIV_BITS'(1);
    end
  end

  assign clk_scan = div[SCAN_DIV_BITS-1 -: 2];

  always_comb begin
    state_n = state;
    score_n = score;
    miss_n  = miss_cnt;
    case (state)
      IDLE: begin
        if (start_rise) begin
          state_n = PLAY;
          score_n = '0;
          miss_n  = '0;
        end
      end
      PLAY: begin
        if (start_rise) begin
          score_n = '0;
          miss_n  = '0;
        end else begin
          if (hit_rise) score_n = bcd_inc(score);
          if (miss_rise) begin
            miss_n = miss_cnt + 4'd1;
            if (miss_n == DIGIT_W'(MAX_MISS)) state_n = OVER;
          end
        end
      end
      OVER: begin
        if (start_rise) begin
          state_n = PLAY;
          score_n = '0;
          miss_n  = '0;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      score     <= '0;
      miss_cnt  <= '0;
      playing   <= 1'b0;
      game_over <= 1'b0;
    end else begin
      state     <= state_n;
      score     <= score_n;
      miss_cnt  <= miss_n;
      playing   <= (state_n == PLAY);
      game_over <= (state_n == OVER);
    end
  end

  assign four_bcd  = score[15:12];
  assign three_bcd = score[11:8];
  assign two_bcd   = score[7:4];
  assign one_bcd   = score[3:0];

endmodule

// File: tb/tb_score_bcd_counter.sv
// Directed bench for score_bcd_counter (SCAN_DIV_BITS=4, MAX_MISS=3).
module tb_score_bcd_counter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       hit = 1'b0;
  logic       miss = 1'b0;
  logic [3:0] four_bcd, three_bcd, two_bcd, one_bcd;
  logic [1:0] clk_scan;
  logic [3:0] miss_cnt;
  logic       playing, game_over;

  int total = 0;
  int bad   = 0;

  score_bcd_counter #(.SCAN_DIV_BITS(4), .MAX_MISS(3)) dut (
    .clk(clk), .rst(rst), .start(start), .hit(hit), .miss(miss),
    .four_bcd(four_bcd), .three_bcd(three_bcd), .two_bcd(two_bcd),
    .one_bcd(one_bcd), .clk_scan(clk_scan), .miss_cnt(miss_cnt),
    .playing(playing), .game_over(game_over)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] score();
    return {four_bcd, three_bcd, two_bcd, one_bcd};
  endfunction

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1; tick(); start = 1'b0; tick();
  endtask

  task automatic pulse_hits(input int n);
    for (int i = 0; i < n; i++) begin
      hit = 1'b1; tick(); hit = 1'b0; tick();
    end
  endtask

  task automatic pulse_miss();
    miss = 1'b1; tick(); miss = 1'b0; tick();
  endtask

  initial begin
    #3;
    check("rst_score", score(), 16'h0000);
    check("rst_miss", 16'(miss_cnt), 16'd0);
    check("rst_playing", 16'(playing), 16'd0);
    check("rst_over", 16'(game_over), 16'd0);
    check("rst_scan", 16'(clk_scan), 16'd0);
    tick();
    rst = 1'b0;
    tick(); tick();

    // 1: start
    pulse_start();
    check("t1_playing", 16'(playing), 16'd1);
    check("t1_score", score(), 16'h0000);
    check("t1_miss", 16'(miss_cnt), 16'd0);

    // 2: separate pulses and a held level
    pulse_hits(12);
    check("t2_12hits", score(), 16'h0012);
    hit = 1'b1;
    repeat (50) tick();
    hit = 1'b0;
    tick();
    check("t2_held", score(), 16'h0013);

    // 3: carry chain and saturation
    pulse_start();
    check("t3_restart", score(), 16'h0000);
    pulse_hits(999);
    check("t3_0999", score(), 16'h0999);
    pulse_hits(1);
    check("t3_1000", score(), 16'h1000);
    pulse_hits(8999);
    check("t3_9999", score(), 16'h9999);
    pulse_hits(1);
    check("t3_sat", score(), 16'h9999);

    // restart wins over a simultaneous hit
    start = 1'b1; hit = 1'b1; tick(); start = 1'b0; hit = 1'b0; tick();
    check("prio_score", score(), 16'h0000);
    check("prio_playing", 16'(playing), 16'd1);

    // 4: miss limit
    pulse_miss(); pulse_miss();
    check("t4_miss2", 16'(miss_cnt), 16'd2);
    check("t4_still_play", 16'(playing), 16'd1);
    pulse_miss();
    check("t4_miss3", 16'(miss_cnt), 16'd3);
    check("t4_over", 16'(game_over), 16'd1);
    check("t4_not_play", 16'(playing), 16'd0);
    pulse_hits(2);
    pulse_miss();
    check("t4_frozen_score", score(), 16'h0000);
    check("t4_frozen_miss", 16'(miss_cnt), 16'd3);

    // 5: simultaneous hit and final miss
    pulse_start();
    check("t5_restart_play", 16'(playing), 16'd1);
    check("t5_restart_miss", 16'(miss_cnt), 16'd0);
    pulse_hits(41);
    pulse_miss(); pulse_miss();
    hit = 1'b1; miss = 1'b1; tick(); hit = 1'b0; miss = 1'b0; tick();
    check("t5_score", score(), 16'h0042);
    check("t5_miss", 16'(miss_cnt), 16'd3);
    check("t5_over", 16'(game_over), 16'd1);

    // 6: async reset mid-game, held start across release
    pulse_start();
    pulse_hits(137);
    check("t6_0137", score(), 16'h0137);
    #2;
    rst = 1'b1;
    start = 1'b1;
    #1;
    check("t6_async_score", score(), 16'h0000);
    check("t6_async_play", 16'(playing), 16'd0);
    check("t6_async_scan", 16'(clk_scan), 16'd0);
    tick();
    rst = 1'b0;
    tick(); tick(); tick();
    check("t6_held_start", 16'(playing), 16'd0);
    start = 1'b0;
    tick();
    pulse_start();
    check("t6_resume", 16'(playing), 16'd1);

    // scan select after a clean reset: divider value = edges since release
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int n = 1; n <= 20; n++) begin
      tick();
      check($sformatf("scan_%0d", n), 16'(clk_scan), 16'((n % 16) / 4));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
